// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - parallel-to-serial word transmitter with inter-word idle gap
module serial_pattern_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    assign din_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // x is driven one cycle ahead of sr: sr always holds the bits not yet placed on x.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            x       <= 1'b0;
            x_en    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        sr      <= advance(din);
                        x       <= head(din);
                        x_en    <= 1'b1;
                        bit_cnt <= BIT_LAST;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        x    <= 1'b0;
                        x_en <= 1'b0;
                        done <= 1'b1;
                        sr   <= '0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LAST;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        x       <= head(sr);
                        sr      <= advance(sr);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] a_din = '0;
    logic       a_din_valid = 1'b0;
    logic       a_din_ready, a_x, a_x_en, a_busy, a_done;

    logic [7:0] b_din = '0;
    logic       b_din_valid = 1'b0;
    logic       b_din_ready, b_x, b_x_en, b_busy, b_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .x(a_x), .x_en(a_x_en), .busy(a_busy), .done(a_done)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .x(b_x), .x_en(b_x_en), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: k = cycles since the accepting edge (0 = nothing in flight).
    // k=1..8 carry bits, k=9 is the done cycle, busy spans k=1..8+gap.
    int         ka = 0, kb = 0;
    logic [7:0] wa = '0, wb = '0;
    int         cyc = 0;
    int         acc_a[$];

    function automatic bit m_busy(input int k, input int gap);
        return (k >= 1) && (k <= 8 + gap);
    endfunction

    function automatic logic m_x(input int k, input logic [7:0] w, input bit msb);
        if (k < 1 || k > 8) return 1'b0;
        return msb ? w[8-k] : w[k-1];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst && a_din_valid && a_din_ready) acc_a.push_back(cyc);
        if (rst) ka = 0;
        else if (a_din_valid && !m_busy(ka, 2)) begin ka = 1; wa = a_din; end
        else if (ka != 0 && ka < 1000) ka++;
        if (rst) kb = 0;
        else if (b_din_valid && !m_busy(kb, 0)) begin kb = 1; wb = b_din; end
        else if (kb != 0 && kb < 1000) kb++;
    end

    logic [7:0] acap = '0, bcap = '0;
    logic [7:0] a_words[$];
    logic [7:0] b_words[$];

    always @(negedge clk) begin
        chk("a_x",     a_x,         m_x(ka, wa, 1'b1));
        chk("a_x_en",  a_x_en,      (ka >= 1 && ka <= 8));
        chk("a_done",  a_done,      (ka == 9));
        chk("a_busy",  a_busy,      m_busy(ka, 2));
        chk("a_ready", a_din_ready, !rst && !m_busy(ka, 2));
        chk("b_x",     b_x,         m_x(kb, wb, 1'b0));
        chk("b_x_en",  b_x_en,      (kb >= 1 && kb <= 8));
        chk("b_done",  b_done,      (kb == 9));
        chk("b_busy",  b_busy,      m_busy(kb, 0));
        chk("b_ready", b_din_ready, !rst && !m_busy(kb, 0));
        if (b_done) chk("b_done_with_ready", b_din_ready, 1);
        if (rst) begin
            acap = '0;
            bcap = '0;
        end else begin
            if (a_x_en) acap = {acap[6:0], a_x};
            if (a_done) begin a_words.push_back(acap); acap = '0; end
            if (b_x_en) bcap = {b_x, bcap[7:1]};
            if (b_done) begin b_words.push_back(bcap); bcap = '0; end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic send_a(input logic [7:0] d, input bit hold);
        bit got = 0;
        a_din = d;
        a_din_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (a_din_ready) got = 1;
            cycle();
        end
        if (!hold) a_din_valid = 1'b0;
        chk("a_accept_in_time", got, 1);
    endtask

    task automatic send_b(input logic [7:0] d);
        bit got = 0;
        b_din = d;
        b_din_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (b_din_ready) got = 1;
            cycle();
        end
        b_din_valid = 1'b0;
        chk("b_accept_in_time", got, 1);
    endtask

    logic [7:0] exp_a[5] = '{8'hB2, 8'hA5, 8'h3C, 8'h00, 8'h81};

    initial begin
        // reset with a word offered: nothing may be taken
        a_din = 8'h55;
        a_din_valid = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_ready_low", a_din_ready, 0);
        rst = 1'b0;
        a_din_valid = 1'b0;
        cycle();
        chk("no_accept_in_reset", acc_a.size(), 0);
        chk("ready_after_reset", a_din_ready, 1);

        send_a(8'b1011_0010, 1'b0);
        repeat (14) cycle();

        send_a(8'hA5, 1'b1);
        a_din = 8'h3C;
        send_a(8'h3C, 1'b0);
        chk("accept_count_t3", acc_a.size(), 3);
        if (acc_a.size() >= 3) chk("accept_spacing", acc_a[2] - acc_a[1], 11);
        repeat (14) cycle();

        send_a(8'h00, 1'b0);
        cycle();
        a_din = 8'hFF;
        a_din_valid = 1'b1;
        repeat (3) cycle();
        a_din_valid = 1'b0;
        repeat (14) cycle();
        chk("accept_count_t4", acc_a.size(), 4);

        send_a(8'hFF, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_x_en", a_x_en, 0);
        chk("abort_busy", a_busy, 0);
        cycle();
        send_a(8'h81, 1'b0);
        repeat (14) cycle();

        send_b(8'b1011_0010);
        repeat (14) cycle();

        chk("a_word_count", a_words.size(), 5);
        for (int i = 0; i < a_words.size() && i < 5; i++) chk("a_word", a_words[i], exp_a[i]);
        chk("b_word_count", b_words.size(), 1);
        if (b_words.size() > 0) chk("b_word", b_words[0], 8'hB2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
